rpn_stack_sequencer: RTL and testbench

Registered, handshaked controller for the team's stack-based ALU datapath. It accepts a stream of RPN tokens (opcode plus data), owns a DEPTH-entry operand stack, and sequences PUSH/ADD/MUL/POP/CLEAR through a small FSM. It flags per-result signed overflow and stack errors, and emits popped values on a valid/ready output port. It sits between a token source (host or decoder) and any downstream result consumer.

---
 rtl/rpn_pkg.sv | 16 +
 rtl/stack_alu_core.sv | 30 +++
 rtl/rpn_stack_sequencer.sv | 124 ++++++++++++
 tb/tb_rpn_stack_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared opcodes and FSM state encoding for the RPN stack sequencer.
package rpn_pkg;

    localparam logic [2:0] OP_PUSH  = 3'b110;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_POP   = 3'b111;
    localparam logic [2:0] OP_CLEAR = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/stack_alu_core.sv
// Combinational ADD/MUL unit: N-bit two's-complement result plus signed-overflow flag.
module stack_alu_core
    import rpn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] result,
    output logic         op_ovf
);

    logic [N-1:0]          sum;
    logic signed [2*N-1:0] prod;

    // NOTE: every output gets a default before the branch, so no path leaves a value held (no latch).
    always_comb begin
        sum    = a + b;
        prod   = (2*N)'($signed(a)) * (2*N)'($signed(b));
        result = sum;
        op_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        if (op == OP_MUL) begin
            result = prod[N-1:0];
            // The product fits only if its upper half is the sign-extension of the low half.
            op_ovf = (prod != {{N{prod[N-1]}}, prod[N-1:0]});
        end
    end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN token sequencer: owns a DEPTH-entry operand stack and runs PUSH/ADD/MUL/POP/CLEAR
// through an IDLE -> EXEC -> (EMIT) FSM with valid/ready ports on both sides.
module rpn_stack_sequencer
    import rpn_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    localparam int SPW  = $clog2(DEPTH + 1),
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_opcode,
    input  logic [N-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic           out_ovf,
    output logic           err_underflow,
    output logic           err_full,
    output logic [SPW-1:0] sp
);

    state_t         state;
    logic [2:0]     op_q;
    logic [N-1:0]   data_q;
    logic [N-1:0]   stack_val [DEPTH];
    logic           stack_ovf [DEPTH];

    logic [IDXW-1:0] top_idx, next_idx;
    logic [N-1:0]    alu_result;
    logic            alu_ovf;
    logic            is_exec, is_arith;
    logic            push_ok, arith_ok, pop_ok;

    assign top_idx  = IDXW'(sp - SPW'(1));
    assign next_idx = IDXW'(sp - SPW'(2));

    assign is_exec  = (state == EXEC);
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_MUL);
    assign push_ok  = is_exec && (op_q == OP_PUSH) && (sp != SPW'(DEPTH));
    assign arith_ok = is_exec && is_arith && (sp >= SPW'(2));
    assign pop_ok   = is_exec && (op_q == OP_POP) && (sp != '0);

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == EMIT);

    stack_alu_core #(.N(N)) u_alu (
        .a      (stack_val[top_idx]),
        .b      (stack_val[next_idx]),
        .op     (op_q),
        .result (alu_result),
        .op_ovf (alu_ovf)
    );

    // NOTE: the stack array is storage only; sp defines which entries are live, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_val[sp[IDXW-1:0]] <= data_q;
            stack_ovf[sp[IDXW-1:0]] <= 1'b0;
        end else if (arith_ok) begin
            stack_val[next_idx] <= alu_result;
            stack_ovf[next_idx] <= stack_ovf[top_idx] | stack_ovf[next_idx] | alu_ovf;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sp            <= '0;
            op_q          <= '0;
            data_q        <= '0;
            out_data      <= '0;
            out_ovf       <= 1'b0;
            err_underflow <= 1'b0;
            err_full      <= 1'b0;
        end else begin
            err_underflow <= 1'b0;
            err_full      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_opcode;
                        data_q <= in_data;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    state <= IDLE;
                    case (op_q)
                        OP_PUSH: begin
                            if (push_ok) sp <= sp + SPW'(1);
                            else         err_full <= 1'b1;
                        end
                        OP_ADD, OP_MUL: begin
                            if (arith_ok) sp <= sp - SPW'(1);
                            else          err_underflow <= 1'b1;
                        end
                        OP_POP: begin
                            if (pop_ok) begin
                                out_data <= stack_val[top_idx];
                                out_ovf  <= stack_ovf[top_idx];
                                sp       <= sp - SPW'(1);
                                state    <= EMIT;
                            end else begin
                                err_underflow <= 1'b1;
                            end
                        end
                        OP_CLEAR: sp <= '0;
                        default: ;
                    endcase
                end
                EMIT: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Scoreboard bench for rpn_stack_sequencer: a reference stack model predicts sp, error
// pulses and popped results; popped results are queued and compared on the output handshake.
module tb_rpn_stack_sequencer;
    import rpn_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_opcode;
    logic [N-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic           out_ovf;
    logic           err_underflow;
    logic           err_full;
    logic [SPW-1:0] sp;

    rpn_stack_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ovf       (out_ovf),
        .err_underflow (err_underflow),
        .err_full      (err_full),
        .sp            (sp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         ovf;
    } exp_t;

    exp_t         exp_q [$];
    logic [N-1:0] m_val [DEPTH];
    logic         m_ovf [DEPTH];
    int           m_sp;
    int           n_checks;
    int           n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model in plain integer arithmetic; overflow is a range test on the exact result.
    task automatic model(input logic [2:0] op, input logic [N-1:0] d,
                         output logic e_uf, output logic e_full);
        int av, bv, r;
        e_uf   = 1'b0;
        e_full = 1'b0;
        case (op)
            OP_PUSH: begin
                if (m_sp == DEPTH) e_full = 1'b1;
                else begin
                    m_val[m_sp] = d;
                    m_ovf[m_sp] = 1'b0;
                    m_sp++;
                end
            end
            OP_ADD, OP_MUL: begin
                if (m_sp < 2) e_uf = 1'b1;
                else begin
                    av = $signed(m_val[m_sp-1]);
                    bv = $signed(m_val[m_sp-2]);
                    r  = (op == OP_ADD) ? av + bv : av * bv;
                    m_ovf[m_sp-2] = m_ovf[m_sp-1] | m_ovf[m_sp-2] |
                                    ((r > (1 << (N-1)) - 1) || (r < -(1 << (N-1))));
                    m_val[m_sp-2] = r[N-1:0];
                    m_sp--;
                end
            end
            OP_POP: begin
                if (m_sp == 0) e_uf = 1'b1;
                else begin
                    m_sp--;
                    exp_q.push_back('{data: m_val[m_sp], ovf: m_ovf[m_sp]});
                end
            end
            OP_CLEAR: m_sp = 0;
            default: ;
        endcase
    endtask

    // Drive one token, check EXEC results, then drain any popped result after `stall` low-ready cycles.
    task automatic send(input logic [2:0] op, input logic [N-1:0] d, input int stall);
        logic e_uf, e_full;
        int   waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        in_valid  = 1'b1;
        in_opcode = op;
        in_data   = d;
        model(op, d, e_uf, e_full);
        @(negedge clk);
        in_valid  = 1'b0;
        in_opcode = 3'($urandom);
        in_data   = N'($urandom);
        check("in_ready_exec", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("sp", 32'(sp), 32'(m_sp));
        check("err_underflow", {31'd0, err_underflow}, {31'd0, e_uf});
        check("err_full", {31'd0, err_full}, {31'd0, e_full});
        if (exp_q.size() > 0) begin
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("in_ready_emit", {31'd0, in_ready}, 32'd0);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", 32'(out_data), 32'(exp_q[0].data));
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            check("out_data", 32'(out_data), 32'(exp_q[0].data));
            check("out_ovf", {31'd0, out_ovf}, {31'd0, exp_q[0].ovf});
            void'(exp_q.pop_front());
            @(negedge clk);
            out_ready = 1'b0;
            check("out_valid_drop", {31'd0, out_valid}, 32'd0);
            check("in_ready_back", {31'd0, in_ready}, 32'd1);
        end else begin
            check("no_output", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        check("err_pulse_end", {30'd0, err_underflow, err_full}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic e_uf, e_full;
        n_checks  = 0;
        n_pass    = 0;
        m_sp      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sp", 32'(sp), 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_errs", {30'd0, err_underflow, err_full}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(OP_POP, 4'h0, 0);

        send(OP_PUSH, 4'h3, 0); send(OP_PUSH, 4'h4, 0); send(OP_ADD, 4'h0, 0);
        send(OP_POP, 4'h0, 0);

        send(OP_PUSH, 4'h7, 0); send(OP_PUSH, 4'h1, 0); send(OP_ADD, 4'h0, 0);
        send(OP_PUSH, 4'h1, 0); send(OP_ADD, 4'h0, 0); send(OP_POP, 4'h0, 1);

        send(OP_PUSH, 4'hE, 0); send(OP_PUSH, 4'h3, 0); send(OP_MUL, 4'h0, 0);
        send(OP_POP, 4'h0, 0);
        send(OP_PUSH, 4'h4, 0); send(OP_PUSH, 4'h4, 0); send(OP_MUL, 4'h0, 0);
        send(OP_POP, 4'h0, 0);

        send(OP_PUSH, 4'h5, 0); send(OP_ADD, 4'h0, 0); send(OP_MUL, 4'h0, 0);
        send(3'b000, 4'h9, 0); send(3'b010, 4'h9, 0); send(3'b011, 4'h9, 0);
        send(OP_CLEAR, 4'h0, 0);

        // Fill to DEPTH, overflow the push, then drain one entry under backpressure.
        for (int i = 0; i < DEPTH; i++) send(OP_PUSH, N'(i + 2), 0);
        send(OP_PUSH, 4'hF, 0);
        send(OP_MUL, 4'h0, 0);
        send(OP_POP, 4'h0, 5);
        send(OP_CLEAR, 4'h0, 0);

        // Reset while a popped value is pending on the output.
        send(OP_PUSH, 4'hB, 0); send(OP_PUSH, 4'h6, 0);
        in_valid  = 1'b1;
        in_opcode = OP_POP;
        model(OP_POP, 4'h0, e_uf, e_full);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("emit_before_rst", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_emit_valid", {31'd0, out_valid}, 32'd0);
        check("rst_emit_sp", 32'(sp), 32'd0);
        check("rst_emit_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        m_sp = 0;
        @(negedge clk);
        check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(OP_POP, 4'h0, 0);
        send(OP_PUSH, 4'h2, 0); send(OP_POP, 4'h0, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
